// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin two-port sequencer for a single-port data memory.
// Ports: clock/reset (async, active-low); A and B request ports (req/we/addr/wdata in,
// ack/err/rdata out); mem_* strobes, address and write data out, mem_result in;
// busy (not IDLE) and owner (0 = A, 1 = B) status.
module data_memory_arbiter #(
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [31:0]           a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic                  a_err,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [31:0]           b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic                  b_err,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [31:0]           mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_result,
    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic                  last_q, last_d;
    logic                  owner_q, owner_d;
    logic                  busy_q, busy_d;
    logic                  a_ack_q, a_ack_d;
    logic                  b_ack_q, b_ack_d;
    logic                  a_err_q, a_err_d;
    logic                  b_err_q, b_err_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
    logic                  mem_write_q, mem_write_d;
    logic                  mem_read_q, mem_read_d;
    logic [31:0]           mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_write_data_q, mem_write_data_d;

    logic                  grant_a;
    logic                  grant_b;
    logic                  sel;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    // last_q = 1 means B was granted last, so A wins a tie
    assign grant_a   = a_req & (~b_req | last_q);
    assign grant_b   = b_req & (~a_req | ~last_q);
    assign sel       = grant_b;
    assign req_we    = sel ? b_we : a_we;
    assign req_addr  = sel ? b_addr : a_addr;
    assign req_wdata = sel ? b_wdata : a_wdata;

    always_comb begin
        state_d          = state_q;
        we_d             = we_q;
        last_d           = last_q;
        owner_d          = owner_q;
        busy_d           = busy_q;
        a_ack_d          = 1'b0;
        b_ack_d          = 1'b0;
        a_err_d          = 1'b0;
        b_err_d          = 1'b0;
        a_rdata_d        = a_rdata_q;
        b_rdata_d        = b_rdata_q;
        mem_write_d      = 1'b0;
        mem_read_d       = 1'b0;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        unique case (state_q)
            IDLE: begin
                if (grant_a | grant_b) begin
                    we_d    = req_we;
                    last_d  = sel;
                    owner_d = sel;
                    busy_d  = 1'b1;
                    if (req_addr >= DEPTH_W) begin
                        // reject: straight to DONE, memory bus untouched
                        state_d = DONE;
                        a_ack_d = ~sel;
                        b_ack_d = sel;
                        a_err_d = ~sel;
                        b_err_d = sel;
                    end else begin
                        // the bus registers double as the latched request
                        state_d          = ISSUE;
                        mem_write_d      = req_we;
                        mem_read_d       = ~req_we;
                        mem_address_d    = req_addr;
                        mem_write_data_d = req_wdata;
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                    a_ack_d = ~owner_q;
                    b_ack_d = owner_q;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d = DONE;
                a_ack_d = ~owner_q;
                b_ack_d = owner_q;
                if (owner_q) b_rdata_d = mem_result;
                else         a_rdata_d = mem_result;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            we_q             <= 1'b0;
            last_q           <= 1'b1;
            owner_q          <= 1'b0;
            busy_q           <= 1'b0;
            a_ack_q          <= 1'b0;
            b_ack_q          <= 1'b0;
            a_err_q          <= 1'b0;
            b_err_q          <= 1'b0;
            a_rdata_q        <= '0;
            b_rdata_q        <= '0;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            we_q             <= we_d;
            last_q           <= last_d;
            owner_q          <= owner_d;
            busy_q           <= busy_d;
            a_ack_q          <= a_ack_d;
            b_ack_q          <= b_ack_d;
            a_err_q          <= a_err_d;
            b_err_q          <= b_err_d;
            a_rdata_q        <= a_rdata_d;
            b_rdata_q        <= b_rdata_d;
            mem_write_q      <= mem_write_d;
            mem_read_q       <= mem_read_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    assign a_ack          = a_ack_q;
    assign b_ack          = b_ack_q;
    assign a_err          = a_err_q;
    assign b_err          = b_err_q;
    assign a_rdata        = a_rdata_q;
    assign b_rdata        = b_rdata_q;
    assign mem_write      = mem_write_q;
    assign mem_read       = mem_read_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign busy           = busy_q;
    assign owner          = owner_q;

endmodule
